// File: rtl/exception_ctrl.sv
// Exception controller: latches masked per-channel requests, arbitrates by
// fixed priority (highest index wins), writes EPC and drives the handler vector.
module exception_ctrl #(
   parameter int DATA_W   = 32,
   parameter int NUM_EXC  = 3,
   parameter int CAUSE_W  = 2,
   parameter int VEC_BASE = 253,
   parameter int PC_ADJ   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_EXC-1:0] exc_req,
   input  logic [NUM_EXC-1:0] exc_mask,
   input  logic [DATA_W-1:0]  pc_in,
   input  logic               exc_ack,
   output logic               exc_busy,
   output logic               exc_pending,
   output logic [CAUSE_W-1:0] exc_cause,
   output logic [DATA_W-1:0]  vec_addr,
   output logic [DATA_W-1:0]  epc,
   output logic               epc_wr
);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t state_q, state_d;

   logic [NUM_EXC-1:0] req_eff;
   logic [NUM_EXC-1:0] cand;
   logic [NUM_EXC-1:0] sel_oh;
   logic [NUM_EXC-1:0] pend_q, pend_d;
   logic [DATA_W-1:0]  pc_q [NUM_EXC];
   logic [DATA_W-1:0]  pc_d [NUM_EXC];
   logic [CAUSE_W-1:0] sel;
   logic [DATA_W-1:0]  cand_pc;
   logic [CAUSE_W-1:0] cause_q, cause_d;
   logic [DATA_W-1:0]  vec_q, vec_d;
   logic [DATA_W-1:0]  epc_q, epc_d;
   logic               wr_q, wr_d;

   assign req_eff = exc_req & ~exc_mask;
   assign cand    = pend_q | req_eff;

   // Ascending scan so the highest set index is the one left standing.
   always_comb begin
      sel     = '0;
      sel_oh  = '0;
      cand_pc = pc_in;
      for (int i = 0; i < NUM_EXC; i++) begin
         if (cand[i]) begin
            sel       = CAUSE_W'(i);
            sel_oh    = '0;
            sel_oh[i] = 1'b1;
            cand_pc   = pend_q[i] ? pc_q[i] : pc_in;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      pc_d    = pc_q;
      cause_d = cause_q;
      vec_d   = vec_q;
      epc_d   = epc_q;
      wr_d    = 1'b0;

      // A channel already pending keeps its first PC; only new bits capture.
      for (int i = 0; i < NUM_EXC; i++) begin
         if (req_eff[i] && !pend_q[i]) begin
            pc_d[i] = pc_in;
         end
      end
      pend_d = pend_q | req_eff;

      unique case (state_q)
         IDLE: begin
            if (|cand) begin
               state_d = BUSY;
               cause_d = sel;
               vec_d   = DATA_W'(VEC_BASE) + DATA_W'(sel);
               epc_d   = cand_pc - DATA_W'(PC_ADJ);
               wr_d    = 1'b1;
               pend_d  = pend_d & ~sel_oh;
            end
         end
         BUSY: begin
            if (exc_ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pend_q  <= '0;
         cause_q <= '0;
         vec_q   <= '0;
         epc_q   <= '0;
         wr_q    <= 1'b0;
         for (int i = 0; i < NUM_EXC; i++) begin
            pc_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         cause_q <= cause_d;
         vec_q   <= vec_d;
         epc_q   <= epc_d;
         wr_q    <= wr_d;
         for (int i = 0; i < NUM_EXC; i++) begin
            pc_q[i] <= pc_d[i];
         end
      end
   end

   assign exc_busy    = (state_q == BUSY);
   assign exc_pending = |pend_q;
   assign exc_cause   = cause_q;
   assign vec_addr    = vec_q;
   assign epc         = epc_q;
   assign epc_wr      = wr_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed and randomized checks of exception_ctrl against a per-channel
// behavioural model of request latching and priority service.
module tb_exception_ctrl;

   logic        clk;
   logic        reset;
   logic [2:0]  exc_req;
   logic [2:0]  exc_mask;
   logic [31:0] pc_in;
   logic        exc_ack;
   logic        exc_busy;
   logic        exc_pending;
   logic [1:0]  exc_cause;
   logic [31:0] vec_addr;
   logic [31:0] epc;
   logic        epc_wr;

   int checks = 0;
   int errors = 0;

   bit          m_pend [3];
   logic [31:0] m_pc   [3];
   bit          m_busy;
   bit          m_wr;
   int          m_cause;
   logic [31:0] m_vec;
   logic [31:0] m_epc;

   exception_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .exc_req     (exc_req),
      .exc_mask    (exc_mask),
      .pc_in       (pc_in),
      .exc_ack     (exc_ack),
      .exc_busy    (exc_busy),
      .exc_pending (exc_pending),
      .exc_cause   (exc_cause),
      .vec_addr    (vec_addr),
      .epc         (epc),
      .epc_wr      (epc_wr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_pend[i] = 0;
         m_pc[i]   = '0;
      end
      m_busy  = 0;
      m_wr    = 0;
      m_cause = 0;
      m_vec   = '0;
      m_epc   = '0;
   endtask

   // What the next rising edge should do, given the inputs now applied.
   task automatic model_edge();
      logic [2:0] eff;
      int win;
      eff = exc_req & ~exc_mask;
      win = -1;
      if (!m_busy) begin
         for (int i = 2; i >= 0; i--) begin
            if (win < 0 && (m_pend[i] || eff[i])) win = i;
         end
      end
      m_wr = 0;
      for (int i = 0; i < 3; i++) begin
         if (i != win && eff[i] && !m_pend[i]) begin
            m_pend[i] = 1;
            m_pc[i]   = pc_in;
         end
      end
      if (win >= 0) begin
         m_epc       = (m_pend[win] ? m_pc[win] : pc_in) - 32'd4;
         m_cause     = win;
         m_vec       = 32'd253 + 32'(win);
         m_wr        = 1;
         m_busy      = 1;
         m_pend[win] = 0;
      end else if (m_busy && exc_ack) begin
         m_busy = 0;
      end
   endtask

   task automatic check_all();
      chk("busy",    32'(exc_busy),    32'(m_busy));
      chk("pending", 32'(exc_pending),
          32'(m_pend[0] | m_pend[1] | m_pend[2]));
      chk("cause",   32'(exc_cause),   32'(m_cause));
      chk("vec",     vec_addr,         m_vec);
      chk("epc",     epc,              m_epc);
      chk("epc_wr",  32'(epc_wr),      32'(m_wr));
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic set_in(input logic [2:0] r, input logic [31:0] pc,
                         input logic a);
      exc_req = r;
      pc_in   = pc;
      exc_ack = a;
   endtask

   // Asynchronous reset between edges; outputs must clear at once.
   task automatic do_reset();
      set_in(3'b000, 32'h0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      chk("rst_busy", 32'(exc_busy), 32'd0);
      chk("rst_pend", 32'(exc_pending), 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      exc_mask = 3'b000;
      set_in(3'b000, 32'h0, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      check_all();
      chk("reset_vec", vec_addr, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // 1: single overflow request
      set_in(3'b010, 32'h108, 1'b0);
      tick();
      chk("t1_vec", vec_addr, 32'd254);
      chk("t1_cause", 32'(exc_cause), 32'd1);
      chk("t1_epc", epc, 32'h104);
      chk("t1_wr", 32'(epc_wr), 32'd1);
      set_in(3'b000, 32'h10c, 1'b0);
      tick();
      chk("t1_wr_once", 32'(epc_wr), 32'd0);
      chk("t1_busy", 32'(exc_busy), 32'd1);
      exc_ack = 1'b1;
      tick();
      chk("t1_ack", 32'(exc_busy), 32'd0);
      exc_ack = 1'b0;
      tick();

      // 2: all three channels at once, served by priority
      set_in(3'b111, 32'h40, 1'b0);
      tick();
      chk("t2_vec0", vec_addr, 32'd255);
      chk("t2_pend0", 32'(exc_pending), 32'd1);
      set_in(3'b000, 32'h44, 1'b1);
      tick();
      exc_ack = 1'b0;
      tick();
      chk("t2_vec1", vec_addr, 32'd254);
      chk("t2_epc1", epc, 32'h3c);
      chk("t2_pend1", 32'(exc_pending), 32'd1);
      exc_ack = 1'b1;
      tick();
      exc_ack = 1'b0;
      tick();
      chk("t2_vec2", vec_addr, 32'd253);
      chk("t2_epc2", epc, 32'h3c);
      chk("t2_pend2", 32'(exc_pending), 32'd0);
      exc_ack = 1'b1;
      tick();
      exc_ack = 1'b0;

      // 3: requests during BUSY merge and keep the first PC
      set_in(3'b010, 32'h200, 1'b0);
      tick();
      set_in(3'b001, 32'h300, 1'b0);
      tick();
      set_in(3'b001, 32'h310, 1'b0);
      tick();
      set_in(3'b000, 32'h314, 1'b1);
      tick();
      exc_ack = 1'b0;
      tick();
      chk("t3_vec", vec_addr, 32'd253);
      chk("t3_epc", epc, 32'h2fc);
      exc_ack = 1'b1;
      tick();
      exc_ack = 1'b0;
      tick();
      chk("t3_wr_none", 32'(epc_wr), 32'd0);

      // 4: masked request is dropped
      exc_mask = 3'b100;
      set_in(3'b100, 32'h400, 1'b0);
      tick();
      tick();
      chk("t4_wr", 32'(epc_wr), 32'd0);
      chk("t4_busy", 32'(exc_busy), 32'd0);
      chk("t4_pend", 32'(exc_pending), 32'd0);
      exc_mask = 3'b000;
      set_in(3'b000, 32'h0, 1'b0);
      tick();

      // 5: EPC wraps below zero
      set_in(3'b001, 32'h2, 1'b0);
      tick();
      chk("t5_epc", epc, 32'hffff_fffe);
      chk("t5_vec", vec_addr, 32'd253);
      set_in(3'b000, 32'h0, 1'b1);
      tick();
      exc_ack = 1'b0;

      // Request in the same cycle as ack is held, then served
      set_in(3'b010, 32'h600, 1'b0);
      tick();
      set_in(3'b100, 32'h700, 1'b1);
      tick();
      set_in(3'b000, 32'h0, 1'b0);
      tick();
      chk("ra_vec", vec_addr, 32'd255);
      chk("ra_epc", epc, 32'h6fc);
      exc_ack = 1'b1;
      tick();
      exc_ack = 1'b0;

      // 6: reset mid-BUSY with pending work
      set_in(3'b010, 32'h500, 1'b0);
      tick();
      set_in(3'b001, 32'h504, 1'b0);
      tick();
      chk("t6_pend_pre", 32'(exc_pending), 32'd1);
      do_reset();
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t6_no_srv", 32'(epc_wr), 32'd0);
      end

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         exc_req  = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
         exc_mask = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
         pc_in    = $urandom;
         exc_ack  = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            tick();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
